// File: rtl/grp_wb_arbiter_if.sv
// Writeback request bus and register-file write port shared by the
// grp write-port arbiter and the sources/register file around it.
interface grp_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic [(2**AW)-1:0]   pend_mask;
  logic [15:0]          conflict_cnt;

  // Requesters and the register file drive/observe the bus from this side.
  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, pend_mask, conflict_cnt
  );

  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata, pend_mask, conflict_cnt
  );
endinterface

// File: rtl/grp_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// pending-write mask for hazard detection and a saturating conflict counter.
module grp_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic            clk,
  input logic            rst_n,
  grp_wb_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       ptr_q, ptr_d;
  logic                rf_wen_q, rf_wen_d;
  logic [AW-1:0]       rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]       rf_wdata_q, rf_wdata_d;
  logic [15:0]         conflict_cnt_q, conflict_cnt_d;

  logic [NREQ-1:0]     grant;
  logic                grant_any;
  logic [PW-1:0]       grant_idx;
  logic [AW-1:0]       win_addr;
  logic [DW-1:0]       win_data;
  logic [(2**AW)-1:0]  pend;
  int                  srch_idx;
  int                  nvalid;

  // Search from ptr upwards; reset and stall both suppress any grant.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    srch_idx  = 0;
    if (rst_n && !bus.stall) begin
      for (int k = 0; k < NREQ; k++) begin
        srch_idx = (int'(ptr_q) + k) % NREQ;
        if (!grant_any && bus.req_valid[srch_idx]) begin
          grant_any = 1'b1;
          grant_idx = PW'(srch_idx);
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    win_addr = bus.req_addr[int'(grant_idx)*AW +: AW];
    win_data = bus.req_data[int'(grant_idx)*DW +: DW];
  end

  always_comb begin
    ptr_d      = ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_any) begin
      ptr_d      = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      rf_wen_d   = (win_addr != '0);
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
    end
  end

  // Contention is counted from raw valids, so stalled cycles count too.
  always_comb begin
    nvalid = 0;
    for (int i = 0; i < NREQ; i++) nvalid = nvalid + int'(bus.req_valid[i]);
    conflict_cnt_d = conflict_cnt_q;
    if (nvalid >= 2 && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  // Register 0 is never marked: writes to it are discarded.
  always_comb begin
    pend = '0;
    for (int r = 1; r < (2**AW); r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_addr[i*AW +: AW] == AW'(r)) pend[r] = 1'b1;
      end
      if (rf_wen_q && rf_waddr_q == AW'(r)) pend[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.rf_wen       = rf_wen_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pend_mask    = pend;
  assign bus.conflict_cnt = conflict_cnt_q;
endmodule
